// File: rtl/ets_acq_controller.sv
// ets_acq_controller: sequences one equivalent-time-sampling sweep around an 8-channel hit counter bank.
// For every delay point it clears the bank, lets the delay line settle, gates counting for
// cfg_window strobes, then streams the eight frozen counts over a valid/ready port.
// Ports: clk/reset (async active-high); start/abort control; cfg_window/cfg_points sweep config;
//   sample_strobe, adder_enable, adder_clr, cnt_in to the counter bank; delay_tap to the delay line;
//   busy/done status; rd_data/rd_chan/rd_valid/rd_ready/rd_last count stream.
// Optional: define ETS_HEADER_EN to prefix each point's burst with a header word carrying the
//   point index, flagged by the extra rd_hdr output.
module ets_acq_controller #(
    parameter int CNT_W      = 32,
    parameter int WIN_W      = 16,
    parameter int PT_W       = 10,
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic [PT_W-1:0]    cfg_points,
    input  logic               sample_strobe,
    output logic               adder_enable,
    output logic               adder_clr,
    input  logic [8*CNT_W-1:0] cnt_in,
    output logic [PT_W-1:0]    delay_tap,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   rd_data,
    output logic [2:0]         rd_chan,
    output logic               rd_valid,
`ifdef ETS_HEADER_EN
    output logic               rd_hdr,
`endif
    input  logic               rd_ready,
    output logic               rd_last
);
`ifdef ETS_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, ACQ, DRAIN, READ, NEXT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d, smp_q, smp_d;
    logic [PT_W-1:0]  pts_q, pts_d, pt_q, pt_d;
    logic [SW-1:0]    set_q, set_d;
    logic [2:0]       chan_q, chan_d;
    logic             hdr_q, hdr_d;
    logic             take;

    assign take = rd_valid && rd_ready;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        pts_d   = pts_q;
        smp_d   = smp_q;
        pt_d    = pt_q;
        set_d   = set_q;
        chan_d  = chan_q;
        hdr_d   = hdr_q;
        case (state_q)
            IDLE: if (start) begin
                win_d   = cfg_window == '0 ? WIN_W'(1) : cfg_window;
                pts_d   = cfg_points == '0 ? PT_W'(1) : cfg_points;
                pt_d    = '0;
                state_d = CLEAR;
            end
            CLEAR: begin
                smp_d   = '0;
                set_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                set_d   = set_q + 1'b1;
                state_d = set_q == SW'(SETTLE_CYC - 1) ? ACQ : SETTLE;
            end
            // the strobe that reaches the window is itself enabled, then counting stops
            ACQ: if (sample_strobe) begin
                smp_d   = smp_q + 1'b1;
                state_d = smp_d == win_q ? DRAIN : ACQ;
            end
            DRAIN: begin
                chan_d  = '0;
                hdr_d   = HDR;
                state_d = READ;
            end
            READ: if (take) begin
                if (hdr_q) begin
                    hdr_d = 1'b0;
                end else if (chan_q == 3'd7) begin
                    chan_d  = '0;
                    state_d = NEXT;
                end else begin
                    chan_d = chan_q + 1'b1;
                end
            end
            NEXT: if (pt_q == pts_q - 1'b1) begin
                state_d = DONE;
            end else begin
                pt_d    = pt_q + 1'b1;
                state_d = CLEAR;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            chan_d  = '0;
            hdr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            pts_q   <= '0;
            smp_q   <= '0;
            pt_q    <= '0;
            set_q   <= '0;
            chan_q  <= '0;
            hdr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            pts_q   <= pts_d;
            smp_q   <= smp_d;
            pt_q    <= pt_d;
            set_q   <= set_d;
            chan_q  <= chan_d;
            hdr_q   <= hdr_d;
        end
    end

    // abort clears the bank and withdraws any offered word in the same cycle
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign adder_clr    = state_q == CLEAR || (abort && busy);
    assign adder_enable = state_q == ACQ && sample_strobe && !abort;
    assign rd_valid     = state_q == READ && !abort;
    assign rd_chan      = chan_q;
    assign rd_last      = rd_valid && !hdr_q && chan_q == 3'd7;
    assign delay_tap    = pt_q;
    assign rd_data      = !rd_valid ? '0 : hdr_q ? CNT_W'(pt_q) : cnt_in[int'(chan_q) * CNT_W +: CNT_W];
`ifdef ETS_HEADER_EN
    assign rd_hdr       = rd_valid && hdr_q;
`endif
endmodule

// File: tb/tb_ets_acq_controller.sv
// tb_ets_acq_controller: directed self-checking bench for ets_acq_controller.
`timescale 1ns/1ps
module tb_ets_acq_controller;
    localparam int CNT_W = 32;
    localparam int WIN_W = 16;
    localparam int PT_W  = 10;
`ifdef ETS_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               sample_strobe = 1'b0;
    logic               rd_ready = 1'b0;
    logic [WIN_W-1:0]   cfg_window = '0;
    logic [PT_W-1:0]    cfg_points = '0;
    logic [8*CNT_W-1:0] cnt_in = '0;
    logic               adder_enable, adder_clr, busy, done, rd_valid, rd_last, rd_hdr;
    logic [PT_W-1:0]    delay_tap;
    logic [CNT_W-1:0]   rd_data;
    logic [2:0]         rd_chan;
    int                 total = 0;
    int                 bad = 0;

    always #5 clk = ~clk;

    ets_acq_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_window(cfg_window), .cfg_points(cfg_points),
        .sample_strobe(sample_strobe), .adder_enable(adder_enable), .adder_clr(adder_clr),
        .cnt_in(cnt_in), .delay_tap(delay_tap), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_chan(rd_chan), .rd_valid(rd_valid),
`ifdef ETS_HEADER_EN
        .rd_hdr(rd_hdr),
`endif
        .rd_ready(rd_ready), .rd_last(rd_last)
    );
`ifndef ETS_HEADER_EN
    assign rd_hdr = 1'b0;
`endif

    task automatic kick(input logic [WIN_W-1:0] w, input logic [PT_W-1:0] p);
        @(negedge clk);
        cfg_window = w;
        cfg_points = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        rd_ready = 1'b1;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            #1;
            ok = done;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s_done: got no done pulse within 400 cycles, want one", name); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({busy, done, rd_valid, rd_last, adder_enable, adder_clr} !== 6'b0 || delay_tap !== '0 || rd_chan !== '0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b last=%b en=%b clr=%b tap=%0d chan=%0d data=%0d, want all 0",
                     busy, done, rd_valid, rd_last, adder_enable, adder_clr, delay_tap, rd_chan, rd_data);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b, want 0", busy); end
    endtask

    task automatic test_basic_sweep();
        int first = -1, nw = 0, hw = 0, en0 = 0, en1 = 0, nclr = 0;
        bit fin = 1'b0;
        sample_strobe = 1'b1;
        rd_ready = 1'b1;
        kick(4, 2);
        cfg_window = 7;
        cfg_points = 5;
        for (int c = 1; c < 200 && !fin; c++) begin
            #1;
            if (adder_enable && delay_tap == 0) en0++;
            if (adder_enable && delay_tap == 1) en1++;
            if (adder_clr) nclr++;
            if (done) fin = 1'b1;
            if (rd_valid && first < 0) first = c;
            if (rd_valid && rd_hdr) begin
                total++;
                if (rd_data !== CNT_W'(hw) || rd_chan !== 3'd0 || rd_last !== 1'b0 || nw != hw * 8) begin
                    bad++;
                    $display("FAIL basic_hdr%0d: got data=%0d chan=%0d last=%b after %0d words, want data=%0d chan=0 last=0 after %0d words",
                             hw, rd_data, rd_chan, rd_last, nw, hw, hw * 8);
                end
                hw++;
            end else if (rd_valid) begin
                total++;
                if (rd_data !== CNT_W'(10 + nw % 8) || rd_chan !== 3'(nw % 8) || rd_last !== (nw % 8 == 7) || delay_tap !== PT_W'(nw / 8)) begin
                    bad++;
                    $display("FAIL basic_word%0d: got data=%0d chan=%0d last=%b tap=%0d, want data=%0d chan=%0d last=%b tap=%0d",
                             nw, rd_data, rd_chan, rd_last, delay_tap, 10 + nw % 8, nw % 8, nw % 8 == 7, nw / 8);
                end
                nw++;
            end
            @(negedge clk);
        end
        total++;
        if (!fin) begin bad++; $display("FAIL basic_done: got no done pulse within 200 cycles, want one"); end
        total++;
        if (first != 11) begin bad++; $display("FAIL basic_latency: got first rd_valid at cycle %0d, want 11", first); end
        total++;
        if (nw != 16 || hw != 2 * HDR) begin bad++; $display("FAIL basic_words: got %0d words %0d headers, want 16 words %0d headers", nw, hw, 2 * HDR); end
        total++;
        if (en0 != 4 || en1 != 4) begin bad++; $display("FAIL basic_enables: got %0d/%0d enable cycles, want 4/4", en0, en1); end
        total++;
        if (nclr != 2) begin bad++; $display("FAIL basic_clears: got %0d adder_clr cycles, want 2", nclr); end
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || delay_tap !== PT_W'(1)) begin
            bad++;
            $display("FAIL basic_after: got busy=%b done=%b tap=%0d, want busy=0 done=0 tap=1", busy, done, delay_tap);
        end
    endtask

    task automatic test_strobe_gaps();
        bit [5:0] pat = 6'b101001;
        int en = 0;
        sample_strobe = 1'b0;
        rd_ready = 1'b1;
        kick(3, 1);
        #1;
        total++;
        if (adder_clr !== 1'b1) begin bad++; $display("FAIL gaps_clear: got adder_clr=%b, want 1", adder_clr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample_strobe = 1'b1;
            #1;
            total++;
            if (adder_enable !== 1'b0) begin bad++; $display("FAIL gaps_settle%0d: got adder_enable=%b, want 0", i, adder_enable); end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample_strobe = pat[i];
            #1;
            total++;
            if (adder_enable !== pat[i]) begin bad++; $display("FAIL gaps_acq%0d: got adder_enable=%b, want %b", i, adder_enable, pat[i]); end
            if (adder_enable) en++;
        end
        @(negedge clk);
        sample_strobe = 1'b1;
        #1;
        total++;
        if (adder_enable !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL gaps_drain: got adder_enable=%b rd_valid=%b, want 0 0", adder_enable, rd_valid);
        end
        @(negedge clk);
        sample_strobe = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b1 || rd_chan !== 3'd0 || en != 3) begin
            bad++;
            $display("FAIL gaps_read: got rd_valid=%b chan=%0d enables=%0d, want 1 0 3", rd_valid, rd_chan, en);
        end
        wait_done("gaps");
    endtask

    task automatic test_backpressure();
        int expc = 0, stall = 0;
        sample_strobe = 1'b1;
        kick(1, 1);
        for (int c = 0; c < 100 && expc < 8; c++) begin
            if (rd_valid && !rd_hdr && rd_chan == 3'd3 && stall < 5) begin
                rd_ready = 1'b0;
                #1;
                total++;
                if (rd_chan !== 3'd3 || rd_data !== CNT_W'(13) || rd_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_stall%0d: got chan=%0d data=%0d valid=%b, want 3 13 1", stall, rd_chan, rd_data, rd_valid);
                end
                stall++;
            end else begin
                rd_ready = 1'b1;
                #1;
                if (rd_valid && !rd_hdr) begin
                    total++;
                    if (rd_chan !== 3'(expc) || rd_data !== CNT_W'(10 + expc)) begin
                        bad++;
                        $display("FAIL bp_word%0d: got chan=%0d data=%0d, want %0d %0d", expc, rd_chan, rd_data, expc, 10 + expc);
                    end
                    expc++;
                end
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (expc != 8 || stall != 5 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_count: got words=%0d stalls=%0d valid_after=%b, want 8 5 0", expc, stall, rd_valid);
        end
        wait_done("bp");
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        int dn = 0;
        sample_strobe = 1'b1;
        rd_ready = 1'b1;
        kick(5, 3);
        for (int c = 0; c < 100 && !found; c++) begin
            #1;
            if (delay_tap == 1) found = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!found || adder_clr !== 1'b1) begin bad++; $display("FAIL abort_reach: got found=%b adder_clr=%b, want 1 1", found, adder_clr); end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (adder_enable !== 1'b1) begin bad++; $display("FAIL abort_acq%0d: got adder_enable=%b, want 1", i, adder_enable); end
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        total++;
        if (adder_clr !== 1'b1 || busy !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_cycle: got clr=%b busy=%b valid=%b, want 1 1 0", adder_clr, busy, rd_valid);
        end
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || adder_clr !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b clr=%b done=%b, want 0 0 0", busy, adder_clr, done);
        end
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (done) dn++;
        end
        total++;
        if (dn != 0) begin bad++; $display("FAIL abort_nodone: got %0d done cycles, want 0", dn); end
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || delay_tap !== '0 || adder_clr !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart: got busy=%b tap=%0d clr=%b, want 1 0 1", busy, delay_tap, adder_clr);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_cleanup: got busy=%b, want 0", busy); end
    endtask

    task automatic test_abort_read();
        bit found = 1'b0;
        sample_strobe = 1'b1;
        rd_ready = 1'b0;
        kick(1, 1);
        for (int c = 0; c < 50 && !found; c++) begin
            #1;
            if (rd_valid) found = 1'b1;
            else @(negedge clk);
        end
        abort = 1'b1;
        #1;
        total++;
        if (!found || rd_valid !== 1'b0 || adder_clr !== 1'b1) begin
            bad++;
            $display("FAIL abort_read: got found=%b valid=%b clr=%b, want 1 0 1", found, rd_valid, adder_clr);
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_read_idle: got busy=%b done=%b, want 0 0", busy, done); end
    endtask

    task automatic test_zero_cfg();
        int en = 0, nw = 0;
        bit fin = 1'b0;
        sample_strobe = 1'b1;
        rd_ready = 1'b1;
        kick(0, 0);
        for (int c = 0; c < 100 && !fin; c++) begin
            #1;
            if (adder_enable) en++;
            if (rd_valid && rd_ready) nw++;
            if (done) fin = 1'b1;
            @(negedge clk);
        end
        total++;
        if (!fin || en != 1 || nw != 8 + HDR || delay_tap !== '0) begin
            bad++;
            $display("FAIL zero_cfg: got done=%b enables=%0d words=%0d tap=%0d, want 1 1 %0d 0", fin, en, nw, delay_tap, 8 + HDR);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int dn = 0;
        sample_strobe = 1'b1;
        rd_ready = 1'b1;
        kick(1, 2);
        for (int c = 0; c < 100 && !found; c++) begin
            #1;
            if (delay_tap == 1 && rd_valid && !rd_hdr && rd_chan == 3'd5) found = 1'b1;
            else @(negedge clk);
        end
        reset = 1'b1;
        #1;
        total++;
        if (!found || {busy, done, rd_valid, rd_last, adder_enable, adder_clr} !== 6'b0 || delay_tap !== '0 || rd_chan !== '0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset_mid: got found=%b busy=%b valid=%b tap=%0d chan=%0d data=%0d, want 1 and all outputs 0",
                     found, busy, rd_valid, delay_tap, rd_chan, rd_data);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            if (done) dn++;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        if (done) dn++;
        total++;
        if (dn != 0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid_after: got done_cycles=%0d busy=%b, want 0 0", dn, busy); end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) cnt_in[k*CNT_W +: CNT_W] = CNT_W'(k + 10);
        test_reset();
        test_basic_sweep();
        test_strobe_gaps();
        test_backpressure();
        test_abort();
        test_abort_read();
        test_zero_cfg();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
